keypad_scanner: RTL and testbench

//   Parametrised matrix keypad scanner with debounce, press/release events and multi-key detect.

---
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks one active-low row at a time, samples the
// active-low columns into a full-matrix frame, debounces whole frames and
// emits press/release events plus held/multi-key levels.
module keypad_scanner #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SCAN_DIV = 1000,
  parameter  int DEBOUNCE = 4,
  localparam int CODE_W   = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic [CODE_W-1:0] keycode,
  output logic              keypressed,
  output logic              keyreleased,
  output logic              keyheld,
  output logic              multikey
);

  localparam int N  = ROWS*COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE+1);

  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_dwell;
  logic [N-1:0]      r_frame;
  logic [N-1:0]      r_prev;
  logic [N-1:0]      r_deb;
  logic [N-1:0]      r_deb_d;
  logic [SW-1:0]     r_stable;
  logic [CODE_W-1:0] r_keycode;
  logic              r_pressed;
  logic              r_released;
  logic              r_held;
  logic              r_multi;

  logic              w_sample;
  logic              w_last_row;
  logic              w_frame_end;
  logic [N-1:0]      w_frame_nxt;
  logic [SW-1:0]     w_stable_nxt;
  logic              w_accept;
  logic              w_multi;
  logic              w_one;
  logic [CODE_W-1:0] w_idx;

  assign w_sample    = (r_dwell == CW'(SCAN_DIV-1));
  assign w_last_row  = (r_row == RW'(ROWS-1));
  assign w_frame_end = w_sample && w_last_row;

  // Row drive is decoded straight from the row index so it changes on the sampling edge.
  assign rows = ~(ROWS'(1) << r_row);

  // Frame with the currently driven row's closed columns merged in.
  always_comb begin
    w_frame_nxt = r_frame;
    for (int r = 0; r < ROWS; r++)
      if (r_row == RW'(r)) w_frame_nxt[r*COLS +: COLS] = ~cols;
  end

  // Debounce count for the frame completing now; accept only on reaching DEBOUNCE.
  always_comb begin
    w_stable_nxt = '0;
    if (w_frame_nxt == r_prev)
      w_stable_nxt = (r_stable == SW'(DEBOUNCE)) ? r_stable : r_stable + SW'(1);
    w_accept = w_frame_end && (r_stable != SW'(DEBOUNCE)) &&
               (w_stable_nxt == SW'(DEBOUNCE));
  end

  // Key index of the debounced matrix; only meaningful when exactly one bit is set.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++)
      if (r_deb[i]) w_idx = CODE_W'(i);
  end

  // Clearing the lowest set bit leaves something only when two or more keys are closed.
  assign w_multi = |(r_deb & (r_deb - N'(1)));
  assign w_one   = (r_deb != '0) && !w_multi;

  // Dwell counter and row walker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_row   <= w_last_row ? '0 : r_row + RW'(1);
    end else begin
      r_dwell <= r_dwell + CW'(1);
    end
  end

  // Frame capture, frame-to-frame comparison and debounced matrix update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_deb    <= '0;
    end else begin
      if (w_sample) r_frame <= w_frame_nxt;
      if (w_frame_end) begin
        r_prev   <= w_frame_nxt;
        r_stable <= w_stable_nxt;
      end
      if (w_accept) r_deb <= w_frame_nxt;
    end
  end

  // Events from the change of the debounced matrix; a press needs empty -> single key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_d    <= '0;
      r_keycode  <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_held     <= 1'b0;
      r_multi    <= 1'b0;
    end else begin
      r_deb_d    <= r_deb;
      r_pressed  <= (r_deb_d == '0) && w_one;
      r_released <= (r_deb_d != '0) && (r_deb == '0);
      r_held     <= |r_deb;
      r_multi    <= w_multi;
      if ((r_deb_d == '0) && w_one) r_keycode <= w_idx;
    end
  end

  assign keycode     = r_keycode;
  assign keypressed  = r_pressed;
  assign keyreleased = r_released;
  assign keyheld     = r_held;
  assign multikey    = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROWS=4 COLS=4 SCAN_DIV=4 DEBOUNCE=2.
// A key matrix model drives the columns from the DUT's row drive.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  keycode;
  logic        keypressed, keyreleased, keyheld, multikey;
  logic [15:0] keys = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;   // posedges since last reset release

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows), .keycode(keycode),
    .keypressed(keypressed), .keyreleased(keyreleased), .keyheld(keyheld),
    .multikey(multikey)
  );

  always #5 clk = ~clk;

  // Closed key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
  end

  task automatic tick;
    @(posedge clk); #1; k++;
  endtask

  task automatic do_reset(input logic [15:0] kset);
    keys = kset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset;
    keys = '0;
    rst_n = 1'b0;
    #3;
    n_chk++;
    if (rows !== 4'b1110) begin
      n_fail++; $display("FAIL reset_rows: got %b expected 1110", rows);
    end
    n_chk++;
    if ({keypressed, keyreleased, keyheld, multikey, keycode} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000000",
                         {keypressed, keyreleased, keyheld, multikey, keycode});
    end
  endtask

  task automatic test_idle_walk;
    logic [3:0] one, exp;
    one = 4'b0001;
    do_reset('0);
    for (int i = 0; i < 160; i++) begin
      tick();
      exp = ~(one << ((k/4) % 4));
      n_chk++;
      if (rows !== exp) begin
        n_fail++; $display("FAIL idle_rows@%0d: got %b expected %b", k, rows, exp);
      end
      n_chk++;
      if ({keypressed, keyreleased, keyheld, multikey, keycode} !== 8'h00) begin
        n_fail++; $display("FAIL idle_outputs@%0d: got %b expected 00000000", k,
                           {keypressed, keyreleased, keyheld, multikey, keycode});
      end
    end
  endtask

  // Key 6 (row 1, col 2) closed from the start: press after the third frame.
  task automatic test_press;
    do_reset(16'h0040);
    for (int i = 0; i < 60; i++) begin
      tick();
      n_chk++;
      if (keypressed !== (k == 49)) begin
        n_fail++; $display("FAIL press_pulse@%0d: got %b expected %b", k, keypressed, k == 49);
      end
      n_chk++;
      if (keyheld !== (k >= 49)) begin
        n_fail++; $display("FAIL press_held@%0d: got %b expected %b", k, keyheld, k >= 49);
      end
      if (k == 49) begin
        n_chk++;
        if (keycode !== 4'd6) begin
          n_fail++; $display("FAIL press_code: got %0d expected 6", keycode);
        end
        n_chk++;
        if (multikey !== 1'b0) begin
          n_fail++; $display("FAIL press_multi: got %b expected 0", multikey);
        end
      end
    end
  endtask

  // Key 6 is open for edges (lo, hi]; otherwise closed. Press expected at edge exp.
  task automatic test_bounce(input int lo, input int hi, input int exp);
    do_reset(lo == 0 ? 16'h0000 : 16'h0040);
    for (int i = 0; i < exp + 12; i++) begin
      tick();
      keys = (k >= lo && k < hi) ? 16'h0000 : 16'h0040;
      n_chk++;
      if (keypressed !== (k == exp)) begin
        n_fail++; $display("FAIL bounce_pulse@%0d: got %b expected %b", k, keypressed, k == exp);
      end
      if (k == exp) begin
        n_chk++;
        if (keycode !== 4'd6) begin
          n_fail++; $display("FAIL bounce_code: got %0d expected 6", keycode);
        end
      end
    end
  endtask

  // Press 6, add 9 after edge 64, release everything after edge 128.
  task automatic test_multikey;
    do_reset(16'h0040);
    for (int i = 0; i < 190; i++) begin
      tick();
      if (k == 64)  keys = 16'h0240;
      if (k == 128) keys = 16'h0000;
      n_chk++;
      if (keypressed !== (k == 49)) begin
        n_fail++; $display("FAIL multi_press@%0d: got %b expected %b", k, keypressed, k == 49);
      end
      n_chk++;
      if (keyreleased !== (k == 177)) begin
        n_fail++; $display("FAIL multi_release@%0d: got %b expected %b", k, keyreleased, k == 177);
      end
      n_chk++;
      if (multikey !== (k >= 113 && k < 177)) begin
        n_fail++; $display("FAIL multi_level@%0d: got %b expected %b", k, multikey,
                           (k >= 113 && k < 177));
      end
      n_chk++;
      if (keyheld !== (k >= 49 && k < 177)) begin
        n_fail++; $display("FAIL multi_held@%0d: got %b expected %b", k, keyheld,
                           (k >= 49 && k < 177));
      end
      n_chk++;
      if (keycode !== ((k >= 49) ? 4'd6 : 4'd0)) begin
        n_fail++; $display("FAIL multi_code@%0d: got %0d expected %0d", k, keycode,
                           (k >= 49) ? 6 : 0);
      end
    end
  endtask

  // Asynchronous reset mid-debounce and while held; key stays closed throughout.
  task automatic test_reset_mid;
    do_reset(16'h0040);
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rows !== 4'b1110) begin
      n_fail++; $display("FAIL midrst_rows: got %b expected 1110", rows);
    end
    n_chk++;
    if ({keypressed, keyreleased, keyheld, multikey} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_flags: got %b expected 0000",
                         {keypressed, keyreleased, keyheld, multikey});
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        n_chk++;
        if (keypressed !== (k == 49)) begin
          n_fail++; $display("FAIL midrst_press%0d@%0d: got %b expected %b", pass, k,
                             keypressed, k == 49);
        end
        n_chk++;
        if (keyreleased !== 1'b0) begin
          n_fail++; $display("FAIL midrst_release%0d@%0d: got %b expected 0", pass, k, keyreleased);
        end
      end
      if (pass == 0) begin
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({keyheld, keycode} !== 5'b0) begin
          n_fail++; $display("FAIL heldrst_outputs: got %b expected 00000", {keyheld, keycode});
        end
        n_chk++;
        if (rows !== 4'b1110) begin
          n_fail++; $display("FAIL heldrst_rows: got %b expected 1110", rows);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_walk();
    test_press();
    test_bounce(0, 16, 65);    // open during the first frame
    test_bounce(16, 32, 81);   // open during the second frame
    test_multikey();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
